// File: rtl/dp_tpp_rotate_ctrl.sv
// Rotation sequencer for dp_triple_pp_buffer: tracks the AXI, NTT and MADD role
// states, pulses o_rotate when all roles are finished and issues engine starts.
module dp_tpp_rotate_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_axi_done,
  input  logic                 i_ntt_done,
  input  logic                 i_madd_done,
  input  logic                 i_drain,
  output logic                 o_rotate,
  output logic [1:0]           o_mode,
  output logic                 o_axi_ready,
  output logic                 o_ntt_start,
  output logic                 o_madd_start,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_batch_cnt,
  output logic                 o_err
);

  typedef enum logic {
    AXI_EMPTY,
    AXI_FULL
  } axi_st_e;

  typedef enum logic [1:0] {
    ROLE_IDLE,
    ROLE_PEND,
    ROLE_BUSY,
    ROLE_DONE
  } role_st_e;

  axi_st_e              axi_st_q, axi_st_d;
  role_st_e             ntt_st_q, ntt_st_d;
  role_st_e             madd_st_q, madd_st_d;
  logic                 rotate_q, rotate_d;
  logic [1:0]           mode_q, mode_d;
  logic                 ntt_start_q, ntt_start_d;
  logic                 madd_start_q, madd_start_d;
  logic [CNT_WIDTH-1:0] batch_cnt_q, batch_cnt_d;
  logic                 err_q, err_d;

  logic axi_ok, ntt_ok, madd_ok, any_valid, rotate_cond;
  logic axi_accept, ntt_accept, madd_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      axi_st_q     <= AXI_EMPTY;
      ntt_st_q     <= ROLE_IDLE;
      madd_st_q    <= ROLE_IDLE;
      rotate_q     <= 1'b0;
      mode_q       <= 2'd0;
      ntt_start_q  <= 1'b0;
      madd_start_q <= 1'b0;
      batch_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      axi_st_q     <= axi_st_d;
      ntt_st_q     <= ntt_st_d;
      madd_st_q    <= madd_st_d;
      rotate_q     <= rotate_d;
      mode_q       <= mode_d;
      ntt_start_q  <= ntt_start_d;
      madd_start_q <= madd_start_d;
      batch_cnt_q  <= batch_cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    axi_st_d     = axi_st_q;
    ntt_st_d     = ntt_st_q;
    madd_st_d    = madd_st_q;
    mode_d       = mode_q;
    ntt_start_d  = 1'b0;
    madd_start_d = 1'b0;
    batch_cnt_d  = batch_cnt_q;

    axi_ok    = (axi_st_q == AXI_FULL) || i_drain;
    ntt_ok    = (ntt_st_q == ROLE_IDLE) || (ntt_st_q == ROLE_DONE);
    madd_ok   = (madd_st_q == ROLE_IDLE) || (madd_st_q == ROLE_DONE);
    any_valid = (axi_st_q == AXI_FULL) || (ntt_st_q != ROLE_IDLE) ||
                (madd_st_q != ROLE_IDLE);
    rotate_cond = axi_ok && ntt_ok && madd_ok && any_valid && !rotate_q;
    rotate_d    = rotate_cond;

    axi_accept  = i_axi_done && (axi_st_q == AXI_EMPTY);
    ntt_accept  = i_ntt_done && (ntt_st_q == ROLE_BUSY);
    madd_accept = i_madd_done && (madd_st_q == ROLE_BUSY);
    err_d = err_q || (i_axi_done && !axi_accept) || (i_ntt_done && !ntt_accept) ||
            (i_madd_done && !madd_accept);

    if (ntt_st_q == ROLE_PEND) begin
      ntt_st_d    = ROLE_BUSY;
      ntt_start_d = 1'b1;
    end
    if (madd_st_q == ROLE_PEND) begin
      madd_st_d    = ROLE_BUSY;
      madd_start_d = 1'b1;
    end
    if (ntt_accept)  ntt_st_d = ROLE_DONE;
    if (axi_accept)  axi_st_d = AXI_FULL;
    if (madd_accept) begin
      madd_st_d   = ROLE_DONE;
      batch_cnt_d = batch_cnt_q + CNT_WIDTH'(1);
    end

    // A fill finishing while a drain rotation fires lands in the RAM becoming NTT-role.
    if (rotate_cond) begin
      ntt_st_d  = ((axi_st_q == AXI_FULL) || axi_accept) ? ROLE_PEND : ROLE_IDLE;
      madd_st_d = (ntt_st_q == ROLE_DONE) ? ROLE_PEND : ROLE_IDLE;
      axi_st_d  = AXI_EMPTY;
      mode_d    = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
    end
  end

  assign o_rotate     = rotate_q;
  assign o_mode       = mode_q;
  assign o_axi_ready  = !rst && (axi_st_q == AXI_EMPTY) && !rotate_q;
  assign o_ntt_start  = ntt_start_q;
  assign o_madd_start = madd_start_q;
  assign o_busy       = any_valid;
  assign o_batch_cnt  = batch_cnt_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_dp_tpp_rotate_ctrl.sv
// Self-checking bench for dp_tpp_rotate_ctrl: directed sequences plus a reactive
// engine model whose expected jobs flow through scoreboard queues.
module tb_dp_tpp_rotate_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_axi_done, i_ntt_done, i_madd_done, i_drain;
  logic        o_rotate, o_axi_ready, o_ntt_start, o_madd_start, o_busy, o_err;
  logic [1:0]  o_mode;
  logic [15:0] o_batch_cnt;

  int testsRun = 0;
  int testsFailed = 0;
  int expMode = 0;
  int expNtt[$];
  int expMadd[$];

  dp_tpp_rotate_ctrl #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_axi_done(i_axi_done), .i_ntt_done(i_ntt_done), .i_madd_done(i_madd_done),
    .i_drain(i_drain),
    .o_rotate(o_rotate), .o_mode(o_mode), .o_axi_ready(o_axi_ready),
    .o_ntt_start(o_ntt_start), .o_madd_start(o_madd_start), .o_busy(o_busy),
    .o_batch_cnt(o_batch_cnt), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at a negedge; returns at the next negedge with pulses cleared.
  task automatic applyStimulus(input logic axi, input logic ntt, input logic madd,
                               input logic drain);
    i_axi_done  = axi;
    i_ntt_done  = ntt;
    i_madd_done = madd;
    i_drain     = drain;
    @(negedge clk);
    i_axi_done  = 1'b0;
    i_ntt_done  = 1'b0;
    i_madd_done = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    i_axi_done = 1'b0; i_ntt_done = 1'b0; i_madd_done = 1'b0; i_drain = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready_low", o_axi_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    expMode = 0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_rotate"}, o_rotate, 0);
    checkOutput({tag, "_mode"}, o_mode, 0);
    checkOutput({tag, "_ready"}, o_axi_ready, 1);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_cnt"}, o_batch_cnt, 0);
    checkOutput({tag, "_err"}, o_err, 0);
  endtask

  // Reactive model: AXI loads when ready, engines answer `lat` cycles after each start.
  task automatic runStream(input int n, input int lat, input int budget);
    int sent = 0, nttCnt = 0, maddCnt = 0, nttJob = 0, maddJob = 0;
    int nextMadd = 0, maddDone = 0, rots = 0, gap = 0, idle = 0;
    logic prevRot = 1'b0, drainLvl = 1'b0;
    logic axi, ntt, madd;
    expNtt.delete();
    expMadd.delete();
    for (int cyc = 0; cyc < budget && idle < 20; cyc++) begin
      axi = 1'b0; ntt = 1'b0; madd = 1'b0;
      if (nttCnt > 0) begin
        nttCnt--;
        if (nttCnt == 0) begin ntt = 1'b1; expMadd.push_back(nttJob); end
      end
      if (maddCnt > 0) begin
        maddCnt--;
        if (maddCnt == 0) begin madd = 1'b1; maddDone++; end
      end
      if (o_rotate) begin
        checkOutput("rot_gap", prevRot, 0);
        expMode = (expMode + 1) % 3;
        checkOutput("rot_mode", o_mode, expMode);
        rots++;
      end
      if (o_ntt_start) begin
        checkOutput("ntt_start_lat", prevRot, 1);
        checkOutput("ntt_job_pending", expNtt.size() > 0, 1);
        if (expNtt.size() > 0) begin nttJob = expNtt.pop_front(); nttCnt = lat; end
      end
      if (o_madd_start) begin
        checkOutput("madd_start_lat", prevRot, 1);
        checkOutput("madd_job_pending", expMadd.size() > 0, 1);
        if (expMadd.size() > 0) begin
          maddJob = expMadd.pop_front();
          checkOutput("madd_order", maddJob, nextMadd);
          nextMadd++;
          maddCnt = lat;
        end
      end
      if (sent < n && o_axi_ready) begin
        if (gap == 0) begin
          axi = 1'b1;
          expNtt.push_back(sent);
          sent++;
          gap = $urandom_range(0, 2);
        end else gap--;
      end
      if (sent == n && !axi) drainLvl = 1'b1;
      if (maddDone == n && !o_busy) idle++;
      prevRot = o_rotate;
      applyStimulus(axi, ntt, madd, drainLvl);
    end
    checkOutput("stream_finished", idle >= 20, 1);
    checkOutput("stream_batch_cnt", o_batch_cnt, n);
    checkOutput("stream_rotations", rots, n + 2);
    checkOutput("stream_madd_starts", nextMadd, n);
    checkOutput("stream_busy_end", o_busy, 0);
    checkOutput("stream_err", o_err, 0);
    i_drain = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic rotSeen;
    doReset();
    checkIdle("reset");

    // Single batch: rotate two cycles after the fill pulse, NTT start one later.
    applyStimulus(1, 0, 0, 0);
    checkOutput("t1_cond_rotate", o_rotate, 0);
    checkOutput("t1_full_ready", o_axi_ready, 0);
    checkOutput("t1_busy", o_busy, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t1_rotate", o_rotate, 1);
    checkOutput("t1_mode", o_mode, 1);
    checkOutput("t1_ntt_early", o_ntt_start, 0);
    checkOutput("t1_ready_rot", o_axi_ready, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t1_ntt_start", o_ntt_start, 1);
    checkOutput("t1_madd_start", o_madd_start, 0);
    checkOutput("t1_rotate_off", o_rotate, 0);
    checkOutput("t1_ready", o_axi_ready, 1);

    doReset();
    runStream(6, 3, 2000);

    // Reset while NTT is busy.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t6_ntt_start", o_ntt_start, 1);
    checkOutput("t6_cnt_before", o_batch_cnt, 6);
    doReset();
    checkIdle("t6");

    runStream(2, 3, 1000);

    // NTT stalls with AXI full: no rotation.
    doReset();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    rotSeen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rotSeen |= o_rotate;
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("t4_no_rotate", rotSeen, 0);
    checkOutput("t4_ready", o_axi_ready, 0);
    checkOutput("t4_busy", o_busy, 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("t4_cond_cycle", o_rotate, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t4_rotate", o_rotate, 1);
    checkOutput("t4_mode", o_mode, 2);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t4_ntt_start", o_ntt_start, 1);
    checkOutput("t4_madd_start", o_madd_start, 1);

    // Spurious done pulses set the sticky error.
    doReset();
    applyStimulus(0, 0, 1, 0);
    checkOutput("t5_err_madd", o_err, 1);
    checkOutput("t5_cnt", o_batch_cnt, 0);
    checkOutput("t5_busy", o_busy, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t5_no_rotate", o_rotate, 0);
    doReset();
    checkOutput("t5_err_cleared", o_err, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("t5_err_first_fill", o_err, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("t5_err_double_fill", o_err, 1);
    checkOutput("t5_rotate", o_rotate, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t5_ntt_start", o_ntt_start, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("t5_err_sticky", o_err, 1);
    checkOutput("t5_mode", o_mode, 1);
    doReset();
    checkOutput("t5_err_rst", o_err, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
